// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: PC reset vector, default word width, queue entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int FETCH_BIT_WIDTH = 32;

    localparam logic [FETCH_BIT_WIDTH-1:0] PC_RESET_VALUE = 32'h40;

    // One buffered fetch: the returned instruction word and the PC it came from.
    typedef struct packed {
        logic [FETCH_BIT_WIDTH-1:0] instr;
        logic [FETCH_BIT_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry pointer/count FIFO holding fetched {instr, pc} entries; flush empties it.
// Latency: a push written at the clock edge is visible at the head the next cycle.
// Backpressure: none internally; the caller guarantees no push while full, pop is ignored when empty or flushing.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  entry_t           push_dat_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             head_vld_o,
    output entry_t           head_dat_o,
    output logic [CNT_W-1:0] count_o
);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               do_push;
    logic               do_pop;

    // Flush overrides both a late-returning push and a same-cycle pop.
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;

    // Next-state for pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer/count registers and entry storage; storage is not cleared by flush (stale head is harmless).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
            end
        end
    end

    assign head_vld_o = (count_q != '0);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch: credit-checked PC advance, synchronous imem read, PC-tagged FIFO to decode.
// Latency: issue in cycle t, entry written end of t+1, instrValid in t+2; one instruction/cycle steady state.
// Backpressure: decode stalls via instrReady; fetch issues only while queued + in-flight < DEPTH (optional FETCH_STATS_EN adds stallCycles/flushCount).
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int BIT_WIDTH      = FETCH_BIT_WIDTH,
    parameter int DEPTH          = 4,
    parameter int IMEM_ADDR_BITS = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BIT_WIDTH-1:0]      pcIn,
    output logic                      pcWrtEn,
    output logic                      imemRdEn,
    output logic [IMEM_ADDR_BITS-1:0] imemAddr,
    input  logic [BIT_WIDTH-1:0]      imemRdata,
    input  logic                      flush,
    output logic                      instrValid,
    input  logic                      instrReady,
    output logic [BIT_WIDTH-1:0]      instrOut,
    output logic [BIT_WIDTH-1:0]      instrPc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]               stallCycles,
    output logic [15:0]               flushCount
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    // Entry layout sized by this instance's word width (matches fetch_entry_t at the default width).
    typedef struct packed {
        logic [BIT_WIDTH-1:0] instr;
        logic [BIT_WIDTH-1:0] pc;
    } entry_t;

    logic                 inflight_q;
    logic [BIT_WIDTH-1:0] inflight_pc_q;
    logic [CNT_W-1:0]     fifo_count;
    logic                 issue;
    entry_t               push_dat;
    entry_t               head_dat;

    // Credit check uses the registered count, so a same-cycle pop never frees a slot early;
    // the outstanding read reserves its slot so the FIFO cannot overflow.
    assign issue = !reset && !flush && ((int'(fifo_count) + int'(inflight_q)) < DEPTH);

    assign pcWrtEn  = issue;
    assign imemRdEn = issue;
    assign imemAddr = pcIn[IMEM_ADDR_BITS+1:2];

    // Track the one outstanding imem read and the PC it was issued from; flush drops it because issue is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pcIn;
            end
        end
    end

    assign push_dat.instr = imemRdata;
    assign push_dat.pc    = inflight_pc_q;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (inflight_q),
        .push_dat_i (push_dat),
        .pop_i      (instrReady),
        .flush_i    (flush),
        .head_vld_o (instrValid),
        .head_dat_o (head_dat),
        .count_o    (fifo_count)
    );

    assign instrOut = head_dat.instr;
    assign instrPc  = head_dat.pc;

`ifdef FETCH_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating counters: cycles with no issue outside flush/reset, and flush events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!issue && !flush && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stallCycles = stall_cnt_q;
    assign flushCount  = flush_cnt_q;
`endif

endmodule
